data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Sequences the MEM stage of the five-stage pipeline against a multi-cycle data memory with a req/ack handshake. It takes the memory controls, address (ALU result) and store data held in the EX/MEM pipeline register, and drives the memory bus. It stalls the pipeline until the access completes and returns load data to MEM/WB. It also detects misaligned accesses, bus errors and bus timeouts, and honours `exception_disable` flushes.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum number of ACCESS cycles without `mem_ack` before a timeout fault; legal range 1..65535.
- `CLK` in 1: single clock; all state updates on posedge.
- `RST` in 1: synchronous, active-high reset.
- `control_mem` in 3: from EX/MEM; [2] branch (ignored here), [1] mem_read, [0] mem_write.
- `ALU_result` in 32: access address.
- `read_data_2` in 32: store data.
- `exception_disable` in 1: flush of the instruction currently in MEM.
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: bus address.
- `mem_wdata` out 32: bus write data.
- `mem_ack` in 1: bus completion.
- `mem_err` in 1: bus error, qualified by `mem_ack`.
- `mem_rdata` in 32: load data, qualified by `mem_ack`.
- `stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `load_data` out 32: captured load data.
- `load_valid` out 1: single-cycle pulse; `load_data` valid.
- `fault` out 1: single-cycle pulse.
- `fault_code` out 2: 01 misaligned, 10 bus error, 11 timeout; held until the next fault.

## Operation
- Access start is `start = (mem_read | mem_write) & ~exception_disable`, evaluated in IDLE only.
- If `mem_read` and `mem_write` are both set, the access is treated as a write.
- Misaligned means `ALU_result[1:0] != 0`.
- **IDLE**
  - `start` and aligned: latch address, write data and `we`; go to ACCESS.
  - `start` and misaligned: go to FAULT with code 01; no bus request is issued.
  - Otherwise: stay in IDLE.
- **ACCESS**
  - `mem_req`=1, with `mem_addr`, `mem_we` and `mem_wdata` held stable from the latched values.
  - `mem_ack & ~mem_err`: capture `mem_rdata` into `load_data` if the access is a read; go to DONE.
  - `mem_ack & mem_err`: go to FAULT with code 10.
  - No ack on the TIMEOUT_CYCLES-th ACCESS cycle: go to FAULT with code 11.
  - An ack on that same cycle wins over the timeout.
- **DONE**
  - Lasts one cycle.
  - `load_valid`=1 for reads that were not killed.
  - Returns to IDLE without evaluating `start`; the inputs still show the completed instruction.
- **FAULT**
  - Lasts one cycle with `fault`=1.
  - Suppressed (no pulse, `fault_code` unchanged) if the access was killed.
  - Returns to IDLE.
- **Flush during ACCESS**
  - `exception_disable`=1 sets a `killed` flag; the bus transaction is never abandoned.
  - `mem_req` is held until `mem_ack`.
  - The result is then discarded: no `load_valid`, no `fault`; `load_data` is not updated.
  - `killed` clears on the return to IDLE.
- **Stall**
  - `stall = (IDLE & start) | ACCESS`.
  - `stall` is combinational from the inputs, so the upstream registers hold on the same edge at which the access is latched.
- **Reset**
  - Synchronous `RST` overrides everything, including an in-flight ACCESS.
  - The memory side is reset by the same `RST`.
  - Reset values: state IDLE; `mem_req`, `mem_we`, `stall`, `load_valid`, `fault` all 0; `mem_addr`, `mem_wdata`, `load_data` all 0; `fault_code` 00; counter 0; `killed` 0.

## Timing
- All outputs except `stall` are registered.
- Best case (ack in the first ACCESS cycle):
  - cycle 0: IDLE, `stall`=1.
  - cycle 1: ACCESS, `mem_req`=1, ack.
  - cycle 2: DONE, `load_valid`=1, `stall`=0.
  - The pipeline therefore stalls for 2 cycles.
- Each extra wait cycle adds one stall cycle.
- Misaligned access:
  - cycle 0: `stall`=1.
  - cycle 1: FAULT, `fault`=1.
- Timeout: `fault` is asserted on cycle `TIMEOUT_CYCLES + 1` after the start cycle.
- The ACCESS-cycle counter is 1 on the first ACCESS cycle and saturates; its width is `$clog2(TIMEOUT_CYCLES+1)`.
- `mem_req` drops in the cycle after the ack is sampled; the bus must not issue an ack without a request.

## Structure
- Package `mips_pipe_pkg`:
  - state enum IDLE/ACCESS/DONE/FAULT;
  - fault code constants FAULT_MISALIGN, FAULT_BUSERR, FAULT_TIMEOUT;
  - control_mem bit indices CM_BRANCH, CM_READ, CM_WRITE.
- One sub-module, `mem_timeout_cnt`: clear/enable saturating counter with an `expired` flag.

## Test plan
- Aligned load to 0x0000_0010, ack in the first ACCESS cycle with rdata 0xDEAD_BEEF -> `stall` high for 2 cycles, `load_valid` pulse with `load_data`=0xDEAD_BEEF, `mem_we`=0.
- Store 0x1234_5678 to 0x20, ack after 3 wait cycles -> `mem_req` held for 4 cycles with stable addr/wdata, `mem_we`=1, `stall` high for 5 cycles, no `load_valid`.
- Load from 0x0000_0013 -> no `mem_req`; `fault` pulse on cycle 1 with `fault_code`=01.
- `TIMEOUT_CYCLES`=4, no ack -> `fault`, `fault_code`=11 on cycle 5, `mem_req` deasserted; variant with ack on the 4th ACCESS cycle -> DONE, no fault.
- `exception_disable` raised in the 2nd ACCESS cycle, ack with `mem_err`=1 on the 3rd -> `mem_req` held until the ack; no `fault`, no `load_valid`; return to IDLE.
- `RST` asserted mid-ACCESS -> next cycle all outputs are at their reset values, state IDLE; a new load then completes normally.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline MEM stage.
package mips_pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 3;

  // control_mem bit positions as delivered by EX/MEM
  localparam int unsigned CM_BRANCH = 2;
  localparam int unsigned CM_READ   = 1;
  localparam int unsigned CM_WRITE  = 0;

  // Fault codes reported on fault_code
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_BUSERR   = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  // MEM-stage sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10,
    FAULT  = 2'b11
  } state_t;

  // Word accesses only: any low address bit set is misaligned
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating ACCESS-cycle counter; expired flags the last allowed cycle.
module mem_timeout_cnt #(
  parameter int unsigned MAX_COUNT = 255,
  parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  // Clear has priority; count stops at MAX_COUNT
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage sequencer: drives a req/ack data bus, stalls the pipe, reports faults.
module data_mem_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CTRL_W-1:0] control_mem,
  input  logic [XLEN-1:0]   ALU_result,
  input  logic [XLEN-1:0]   read_data_2,
  input  logic              exception_disable,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_err,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              stall,
  output logic [XLEN-1:0]   load_data,
  output logic              load_valid,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state;
  logic             killed;
  logic             start;
  logic             misaligned;
  logic             kill_now;
  logic             cnt_en;
  logic             cnt_expired;
  logic [CNT_W-1:0] acc_cnt;
  logic             unused_sig;

  assign start      = (control_mem[CM_READ] | control_mem[CM_WRITE]) & ~exception_disable;
  assign misaligned = is_misaligned(ALU_result);
  // A flush arriving on the completing cycle still discards the result
  assign kill_now   = killed | exception_disable;

  // Upstream registers must hold on the very edge that latches the access
  assign stall = ((state == IDLE) && start) || (state == ACCESS);

  // Counter runs from the launch edge so it reads 1 on the first ACCESS cycle
  assign cnt_en = ((state == IDLE) && start && !misaligned) || (state == ACCESS);

  assign unused_sig = ^{control_mem[CM_BRANCH], acc_cnt};

  mem_timeout_cnt #(
    .MAX_COUNT (TIMEOUT_CYCLES),
    .CNT_W     (CNT_W)
  ) u_timeout_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (!cnt_en),
    .en      (cnt_en),
    .count   (acc_cnt),
    .expired (cnt_expired)
  );

  // Sequencer with registered bus, pulse and fault outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      killed     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      load_valid <= 1'b0;
      fault      <= 1'b0;
      case (state)
        IDLE: begin
          killed <= 1'b0;
          if (start) begin
            if (misaligned) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= FAULT_MISALIGN;
            end else begin
              state     <= ACCESS;
              mem_req   <= 1'b1;
              mem_addr  <= ALU_result;
              mem_wdata <= read_data_2;
              mem_we    <= control_mem[CM_WRITE];
            end
          end
        end
        ACCESS: begin
          if (exception_disable) begin
            killed <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_err) begin
              state <= FAULT;
              if (!kill_now) begin
                fault      <= 1'b1;
                fault_code <= FAULT_BUSERR;
              end
            end else begin
              state <= DONE;
              if (!kill_now && !mem_we) begin
                load_data  <= mem_rdata;
                load_valid <= 1'b1;
              end
            end
          end else if (cnt_expired) begin
            mem_req <= 1'b0;
            state   <= FAULT;
            if (!kill_now) begin
              fault      <= 1'b1;
              fault_code <= FAULT_TIMEOUT;
            end
          end
        end
        DONE: begin
          killed <= 1'b0;
          state  <= IDLE;
        end
        FAULT: begin
          killed <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized scoreboard bench for data_mem_ctrl with a bus responder model.
module tb_data_mem_ctrl;

  localparam int unsigned T = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  control_mem;
  logic [31:0] ALU_result;
  logic [31:0] read_data_2;
  logic        exception_disable;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;
  logic [1:0]  fault_code;

  always #5 CLK = ~CLK;

  data_mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .control_mem       (control_mem),
    .ALU_result        (ALU_result),
    .read_data_2       (read_data_2),
    .exception_disable (exception_disable),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_err           (mem_err),
    .mem_rdata         (mem_rdata),
    .stall             (stall),
    .load_data         (load_data),
    .load_valid        (load_valid),
    .fault             (fault),
    .fault_code        (fault_code)
  );

  typedef struct {
    bit          is_fault;
    logic [1:0]  code;
    logic [31:0] data;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_load = '0;
  logic [1:0]  model_code = 2'b00;

  // Bus plan for the current instruction
  int          plan_lat   = 0;
  bit          plan_err   = 1'b0;
  logic [31:0] plan_rdata = '0;
  logic [31:0] exp_addr   = '0;
  logic [31:0] exp_wdata  = '0;
  bit          exp_we     = 1'b0;
  int          req_total  = 0;
  int          acc_n      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: acks after plan_lat wait cycles, checks held bus fields
  always @(negedge CLK) begin
    if (RST || !mem_req) begin
      acc_n     = 0;
      mem_ack   = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = $urandom;
    end else begin
      acc_n++;
      req_total++;
      chk("bus_addr", mem_addr, exp_addr);
      chk("bus_wdata", mem_wdata, exp_wdata);
      chk("bus_we", 32'(mem_we), 32'(exp_we));
      if (acc_n == plan_lat + 1) begin
        mem_ack   = 1'b1;
        mem_err   = plan_err;
        mem_rdata = plan_rdata;
      end else begin
        mem_ack   = 1'b0;
        mem_err   = 1'($urandom);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every pulse must match the next expected event
  always @(negedge CLK) begin : monitor
    ev_t e;
    if (!RST && (load_valid || fault)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({load_valid, fault}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 32'({load_valid, fault}), e.is_fault ? 32'd1 : 32'd2);
        if (e.is_fault) begin
          chk("fault_code", 32'(fault_code), 32'(e.code));
          model_code = e.code;
        end else begin
          chk("load_data", load_data, e.data);
          model_load = e.data;
        end
      end
    end
  end

  // One EX/MEM instruction; flush_k: 0 none, -1 flushed before start, k>0 on k-th ACCESS cycle
  task automatic op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                    input int lat, input bit err, input logic [31:0] rval, input int flush_k);
    ev_t e;
    bit  has_ev;
    bit  go;
    int  exp_stall;
    int  exp_req;
    int  stall_cnt;
    int  acc;
    @(negedge CLK);
    chk("load_data_hold", load_data, model_load);
    chk("fault_code_hold", 32'(fault_code), 32'(model_code));
    has_ev    = 1'b0;
    exp_stall = 0;
    exp_req   = 0;
    go        = (rd || wr) && (flush_k >= 0);
    if (go) begin
      if (addr[1:0] != 2'b00) begin
        exp_stall = 1;
        has_ev    = 1'b1;
        e         = '{1'b1, 2'b01, 32'd0};
      end else if (lat >= int'(T)) begin
        exp_stall = T + 1;
        exp_req   = T;
        has_ev    = (flush_k == 0);
        e         = '{1'b1, 2'b11, 32'd0};
      end else begin
        exp_stall = lat + 2;
        exp_req   = lat + 1;
        if (flush_k == 0 && err) begin
          has_ev = 1'b1;
          e      = '{1'b1, 2'b10, 32'd0};
        end else if (flush_k == 0 && rd && !wr) begin
          has_ev = 1'b1;
          e      = '{1'b0, 2'b00, rval};
        end
      end
    end
    if (has_ev) sb.push_back(e);
    exp_addr          = addr;
    exp_wdata         = wd;
    exp_we            = wr;
    plan_lat          = lat;
    plan_err          = err;
    plan_rdata        = rval;
    req_total         = 0;
    control_mem       = {1'($urandom), rd, wr};
    ALU_result        = addr;
    read_data_2       = wd;
    exception_disable = (flush_k < 0);
    stall_cnt         = 0;
    acc               = 0;
    #1;
    while (stall) begin
      stall_cnt++;
      if (stall_cnt > 200) begin
        chk("stall_bound", 32'(stall_cnt), 32'(exp_stall));
        break;
      end
      @(negedge CLK);
      if (flush_k > 0 && mem_req) begin
        acc++;
        if (acc == flush_k) exception_disable = 1'b1;
      end
      #1;
    end
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    chk("req_cycles", 32'(req_total), 32'(exp_req));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_load_valid"}, 32'(load_valid), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_fault_code"}, 32'(fault_code), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    bit          rd, wr;
    logic [31:0] a;
    int          lat, fk;
    RST               = 1'b1;
    control_mem       = 3'b000;
    ALU_result        = '0;
    read_data_2       = '0;
    exception_disable = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("por");
    RST = 1'b0;

    op(1, 0, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);     // best-case load
    op(0, 1, 32'h0000_0020, 32'h1234_5678, 3, 0, 32'h0, 0);      // store, 3 waits
    op(1, 0, 32'h0000_0013, 32'h0, 0, 0, 32'h0, 0);              // misaligned load
    op(1, 0, 32'h0000_0040, 32'h0, 50, 0, 32'h0, 0);             // timeout
    op(1, 0, 32'h0000_0044, 32'h0, T - 1, 0, 32'hCAFE_F00D, 0);  // ack on last allowed cycle
    op(1, 0, 32'h0000_0048, 32'h0, 2, 1, 32'h0, 2);              // flushed bus error
    op(1, 1, 32'h0000_004C, 32'hA5A5_5A5A, 1, 0, 32'h0, 0);      // read+write acts as write
    op(0, 0, 32'h0000_0003, 32'h0, 0, 0, 32'h0, 0);              // no memory access
    op(1, 0, 32'h0000_0050, 32'h0, 0, 0, 32'h1111_2222, -1);     // flushed before start
    op(0, 1, 32'h0000_0054, 32'h0BAD_0BAD, 0, 1, 32'h0, 0);      // store bus error

    // Reset during an in-flight access
    @(negedge CLK);
    exp_addr          = 32'h0000_0060;
    exp_wdata         = 32'h7777_7777;
    exp_we            = 1'b0;
    plan_lat          = 100;
    control_mem       = 3'b010;
    ALU_result        = 32'h0000_0060;
    read_data_2       = 32'h7777_7777;
    exception_disable = 1'b0;
    repeat (2) @(negedge CLK);
    RST         = 1'b1;
    control_mem = 3'b000;
    @(negedge CLK);
    check_reset_values("mid");
    RST        = 1'b0;
    model_load = '0;
    model_code = 2'b00;
    op(1, 0, 32'h0000_0064, 32'h0, 1, 0, 32'h0F0F_F0F0, 0);

    for (int i = 0; i < 300; i++) begin
      rd  = 1'($urandom);
      wr  = 1'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      lat = $urandom_range(0, 6);
      fk  = 0;
      if (a[1:0] == 2'b00 && lat < int'(T) && $urandom_range(0, 3) == 0)
        fk = $urandom_range(1, lat + 1);
      else if ($urandom_range(0, 15) == 0)
        fk = -1;
      op(rd, wr, a, $urandom, lat, ($urandom_range(0, 4) == 0), $urandom, fk);
    end

    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
